seq_frame_scheduler: RTL and testbench
======================================

Name: seq_frame_scheduler

Overview:
- Shares one serial sequence-detector FSM (ports a / ready / reset in, w out) between two requesters.
- Each requester hands over a FRAME_W-bit frame. The scheduler grants one requester, clears the detector, then feeds the frame into it one bit per cycle.
- It counts the cycles in which the detector asserts w and returns that hit count with a done pulse.
- Sits between the stimulus/host logic and the detector instance; the detector itself is unchanged.

Parameters:
- FRAME_W, 8, bits per frame, fed LSB first; legal range 2..32.
- HIT_W, $clog2(FRAME_W+1), hit-count width; localparam derived from FRAME_W, not overridable.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  request; req[i] high means requester i has a frame ready.
- data0  in  FRAME_W  frame of requester 0; sampled only in the grant cycle.
- data1  in  FRAME_W  frame of requester 1; sampled only in the grant cycle.
- gnt  out  2  one-hot grant; held from CLR through DONE.
- done  out  2  one-cycle pulse on the granted bit, in DONE.
- hits  out  HIT_W  detections in the last frame; valid while done is high, held until next DONE.
- det_reset  out  1  drives the detector reset.
- det_a  out  1  serial bit to the detector.
- det_ready  out  1  bit-valid strobe to the detector.
- det_w  in  1  detector Moore output; registered, reflects the bit presented in the previous cycle.

Behaviour:
- Reset values: gnt=0, done=0, hits=0, det_reset=1, det_a=0, det_ready=0; state=IDLE; RR pointer=0 (requester 0 preferred next); bit counter=0; hit counter=0.
- Reset mid-frame aborts immediately: no done pulse, hits cleared, pointer back to 0.
- States:
  - IDLE: det_reset=0. If any req bit is high, pick the winner, latch its data into the shift register, set gnt, go to CLR. Otherwise stay.
  - CLR (1 cycle): det_reset=1, hit counter cleared, bit counter=0.
  - SHIFT (FRAME_W cycles): det_ready=1, det_a=shift_reg[0], shift right each cycle. From the 2nd SHIFT cycle on, hit counter += det_w. After bit FRAME_W-1, go to DRAIN.
  - DRAIN (1 cycle): det_ready=0, det_a=0; hit counter += det_w (response to the last bit).
  - DONE (1 cycle): hits <= hit counter, done[winner]=1. Pointer moves to the other requester, gnt cleared on exit, go to IDLE.
- Latency: req seen in IDLE at cycle t gives gnt at t+1 and done at t+FRAME_W+3. Back-to-back frames occupy FRAME_W+4 cycles each, including one IDLE cycle.
- Arbitration: round-robin. If both req are high, the pointer owner wins. A single req wins regardless of the pointer. The pointer updates only in DONE.
- Requester dropping req mid-frame: ignored; the frame completes and done still pulses. req still high after done is treated as a new frame on the next IDLE.
- Data changes after the grant cycle have no effect.
- Hit counter cannot overflow: at most FRAME_W hits, and HIT_W covers FRAME_W.

Optional Feature:
- Macro: SEQ_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins when both request; pointer logic removed.
- Undefined: round-robin as above.

Decomposition:
- Shared package: state encoding constants (IDLE, CLR, SHIFT, DRAIN, DONE) and requester index constants REQ0 and REQ1.
- One natural sub-module: seq_rr_arbiter2. It takes req and an advance strobe and produces a one-hot winner. It owns the pointer and the fixed-priority macro.

Test Plan:
- Bench detector model: w=1 one cycle after two consecutive 1 bits with ready high (overlapping "11"); FRAME_W=8.
- Reset held 2 cycles, then released -> all outputs at reset values; det_reset=1 during reset, 0 in IDLE.
- req=01, data0=8'h07 -> gnt=01 at t+1, det_a sequence 1,1,1,0,0,0,0,0, done=01 at t+11, hits=2.
- req=11 held, data0=8'hFF, data1=8'h00 -> grants alternate 01,10,01; hits 7,0,7; done spacing 12 cycles. With SEQ_SCHED_FIXED_PRIO_EN: gnt always 01.
- req=10, data1=8'h55; req dropped and data1 changed to 8'hFF after the grant cycle -> frame still completes, hits=0, done=10.
- reset asserted at SHIFT cycle 4 with data0=8'hFF -> next cycle IDLE, gnt=0, no done pulse, hits=0; next req=11 grants requester 0.

Source files
------------

// File: rtl/seq_frame_scheduler_pkg.sv
// Shared encodings for the frame scheduler and its arbiter.
package seq_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    DRAIN,
    DONE
  } state_e;

  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

endpackage

// File: rtl/seq_rr_arbiter2.sv
// Two-way round-robin arbiter; SEQ_SCHED_FIXED_PRIO_EN makes
// requester 0 the fixed winner and drops the pointer.
module seq_rr_arbiter2
  import seq_frame_scheduler_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic [1:0] owner,
  output logic [1:0] win
);

`ifdef SEQ_SCHED_FIXED_PRIO_EN
  logic unused_arb;
  assign unused_arb = ^{clock, reset, advance, owner};

  always_comb begin
    win = '0;
    if (req[REQ0]) begin
      win[REQ0] = 1'b1;
    end else if (req[REQ1]) begin
      win[REQ1] = 1'b1;
    end
  end
`else
  logic ptr_q;
  logic ptr_d;

  // Pointer names the requester preferred on the next tie.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = owner[REQ0];
    end
  end

  always_comb begin
    win = '0;
    if (req[REQ0] && (!req[REQ1] || !ptr_q)) begin
      win[REQ0] = 1'b1;
    end else if (req[REQ1]) begin
      win[REQ1] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: rtl/seq_frame_scheduler.sv
// Shares one serial sequence detector between two frame requesters.
// SEQ_SCHED_FIXED_PRIO_EN selects fixed priority in the arbiter.
module seq_frame_scheduler
  import seq_frame_scheduler_pkg::*;
#(
  parameter  int FRAME_W = 8,
  localparam int HIT_W   = $clog2(FRAME_W + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [FRAME_W-1:0] data0,
  input  logic [FRAME_W-1:0] data1,
  output logic [1:0]         gnt,
  output logic [1:0]         done,
  output logic [HIT_W-1:0]   hits,
  output logic               det_reset,
  output logic               det_a,
  output logic               det_ready,
  input  logic               det_w
);

  localparam int CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

  state_e             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HIT_W-1:0]   hit_q, hit_d;
  logic [HIT_W-1:0]   hits_q, hits_d;
  logic [1:0]         win;
  logic               advance;

  seq_rr_arbiter2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .owner   (gnt_q),
    .win     (win)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    hit_d     = hit_q;
    hits_d    = hits_q;
    advance   = 1'b0;
    done      = '0;
    det_a     = 1'b0;
    det_ready = 1'b0;
    det_reset = reset;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = win;
          sh_d    = win[REQ1] ? data1 : data0;
          state_d = CLR;
        end
      end
      CLR: begin
        det_reset = 1'b1;
        hit_d     = '0;
        cnt_d     = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        det_ready = 1'b1;
        det_a     = sh_q[0];
        sh_d      = sh_q >> 1;
        cnt_d     = cnt_q + 1'b1;
        // det_w in the first SHIFT cycle still reflects the clear
        if (cnt_q != '0) begin
          hit_d = hit_q + HIT_W'(det_w);
        end
        if (cnt_q == LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        hit_d   = hit_q + HIT_W'(det_w);
        hits_d  = hit_d;
        state_d = DONE;
      end
      DONE: begin
        done    = gnt_q;
        advance = 1'b1;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      hit_q   <= '0;
      hits_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      hits_q  <= hits_d;
    end
  end

  assign gnt  = gnt_q;
  assign hits = hits_q;

endmodule

// File: tb/tb_seq_frame_scheduler.sv
// Directed bench for seq_frame_scheduler with an "11" detector model.
module tb_seq_frame_scheduler;

  localparam int FRAME_W = 8;
  localparam int HIT_W   = 4;

  logic               clock;
  logic               reset;
  logic [1:0]         req;
  logic [FRAME_W-1:0] data0;
  logic [FRAME_W-1:0] data1;
  logic [1:0]         gnt;
  logic [1:0]         done;
  logic [HIT_W-1:0]   hits;
  logic               det_reset;
  logic               det_a;
  logic               det_ready;
  logic               det_w;

  int checks;
  int errors;
  int cyc;
  int last_done;

  seq_frame_scheduler #(.FRAME_W(FRAME_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .gnt       (gnt),
    .done      (done),
    .hits      (hits),
    .det_reset (det_reset),
    .det_a     (det_a),
    .det_ready (det_ready),
    .det_w     (det_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Detector: w one cycle after two consecutive accepted 1 bits
  logic prev_q;
  always @(posedge clock) begin
    if (det_reset) begin
      det_w  <= 1'b0;
      prev_q <= 1'b0;
    end else if (det_ready) begin
      det_w  <= det_a & prev_q;
      prev_q <= det_a;
    end else begin
      det_w  <= 1'b0;
    end
  end

  typedef struct {
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       drop;
    logic       b2b;
    logic [1:0] gnt;
    logic [3:0] hits;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered at the negedge of an IDLE cycle.
  task automatic run_frame(input vec_t v);
    logic [7:0] exp_bits;
    logic [7:0] got;
    int k;
    int nb;
    req   = v.req;
    data0 = v.d0;
    data1 = v.d1;
    chk("idle_det_reset", det_reset, 0);
    @(negedge clock);
    chk("gnt", gnt, v.gnt);
    chk("clr_det_reset", det_reset, 1);
    exp_bits = v.gnt[1] ? v.d1 : v.d0;
    if (v.drop) begin
      req   = 2'b00;
      data1 = 8'hFF;
    end
    k  = 1;
    nb = 0;
    got = '0;
    while (done == 2'b00 && k < 20) begin
      @(negedge clock);
      k++;
      if (det_ready) begin
        if (nb < 8) got[nb] = det_a;
        nb++;
      end
    end
    chk("latency", k, FRAME_W + 3);
    chk("nbits", nb, FRAME_W);
    chk("det_a_seq", got, exp_bits);
    chk("done", done, v.gnt);
    chk("hits", hits, v.hits);
    chk("gnt_in_done", gnt, v.gnt);
    if (v.b2b) chk("done_spacing", cyc - last_done, FRAME_W + 4);
    last_done = cyc;
    @(negedge clock);
    chk("idle_gnt", gnt, 0);
    chk("idle_done", done, 0);
    chk("hits_held", hits, v.hits);
  endtask

  vec_t tbl[5];
  vec_t v07;
  vec_t vab;
  logic saw_done;

  initial begin
    checks    = 0;
    errors    = 0;
    last_done = 0;
`ifdef SEQ_SCHED_FIXED_PRIO_EN
    tbl[0] = '{2'b11, 8'hFF, 8'h00, 1'b0, 1'b0, 2'b01, 4'd7};
    tbl[1] = '{2'b11, 8'hFF, 8'h00, 1'b0, 1'b1, 2'b01, 4'd7};
    tbl[2] = '{2'b11, 8'hFF, 8'h00, 1'b0, 1'b1, 2'b01, 4'd7};
`else
    tbl[0] = '{2'b11, 8'hFF, 8'h00, 1'b0, 1'b0, 2'b01, 4'd7};
    tbl[1] = '{2'b11, 8'hFF, 8'h00, 1'b0, 1'b1, 2'b10, 4'd0};
    tbl[2] = '{2'b11, 8'hFF, 8'h00, 1'b0, 1'b1, 2'b01, 4'd7};
`endif
    tbl[3] = '{2'b01, 8'h07, 8'h00, 1'b0, 1'b0, 2'b01, 4'd2};
    tbl[4] = '{2'b10, 8'h00, 8'h55, 1'b1, 1'b0, 2'b10, 4'd0};
    v07    = '{2'b01, 8'h07, 8'h00, 1'b0, 1'b0, 2'b01, 4'd2};
    vab    = '{2'b11, 8'hFF, 8'h00, 1'b0, 1'b0, 2'b01, 4'd7};

    reset = 1'b1;
    req   = 2'b00;
    data0 = '0;
    data1 = '0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_hits", hits, 0);
    chk("rst_det_reset", det_reset, 1);
    chk("rst_det_a", det_a, 0);
    chk("rst_det_ready", det_ready, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_after_rst", det_reset, 0);

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i]);
    end

    // Leave the pointer on requester 1, then abort mid-frame
    run_frame(v07);
    req   = 2'b01;
    data0 = 8'hFF;
    @(negedge clock);
    chk("abort_gnt", gnt, 2'b01);
    repeat (4) @(negedge clock);
    chk("abort_shift", det_ready, 1);
    reset = 1'b1;
    req   = 2'b00;
    @(negedge clock);
    chk("abort_gnt0", gnt, 0);
    chk("abort_done0", done, 0);
    chk("abort_hits0", hits, 0);
    chk("abort_ready0", det_ready, 0);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (done != 2'b00) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    run_frame(vab);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
